// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous RAM (2**ADDR_W x DATA_W)
//                between three requesters: CPU, GPU sprite engine and video
//                scanout (vid). Writes are fire-and-forget strobes and always
//                take the RAM port. Reads are level requests that are granted
//                in a write-free cycle and acknowledged exactly one cycle
//                later, together with the RAM read data.
//
//  Ports       : clk, reset            clock, synchronous active-high reset
//                cpu_read*/cpu_write*  CPU read (req/idx/byte/ack), write group
//                gpu_read*/gpu_write*  GPU read (req/idx/byte/ack), write group
//                vid_read*             scanout read group (read-only)
//                ram_addr/we/wdata     RAM command (sole driver)
//                ram_rdata             RAM data, one cycle after the address
//                write_conflict        sticky: a GPU write was dropped
//
//  Options     : MEM_ARB_ROUND_ROBIN_EN -- when defined, CPU and GPU reads
//                share bandwidth round-robin (vid keeps absolute priority).
//                When undefined, reads use fixed priority vid > cpu > gpu.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    // CPU
    input  logic              cpu_read,
    input  logic [ADDR_W-1:0] cpu_read_idx,
    output logic [DATA_W-1:0] cpu_read_byte,
    output logic              cpu_read_ack,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_write_idx,
    input  logic [DATA_W-1:0] cpu_write_byte,
    // GPU sprite engine
    input  logic              gpu_read,
    input  logic [ADDR_W-1:0] gpu_read_idx,
    output logic [DATA_W-1:0] gpu_read_byte,
    output logic              gpu_read_ack,
    input  logic              gpu_write,
    input  logic [ADDR_W-1:0] gpu_write_idx,
    input  logic [DATA_W-1:0] gpu_write_byte,
    // Video scanout
    input  logic              vid_read,
    input  logic [ADDR_W-1:0] vid_read_idx,
    output logic [DATA_W-1:0] vid_read_byte,
    output logic              vid_read_ack,
    // RAM
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    // Status
    output logic              write_conflict
);

    // Read port identifiers used by the pending tag.
    localparam logic [1:0] c_PORT_VID = 2'd0;
    localparam logic [1:0] c_PORT_CPU = 2'd1;
    localparam logic [1:0] c_PORT_GPU = 2'd2;

    // Pending read tag: set in the grant cycle, consumed in the following one.
    logic              r_tag_valid;
    logic [1:0]        r_tag_port;
    // RAM address is held while the port is idle.
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_conflict;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 0 = CPU wins the next cpu/gpu tie, 1 = GPU wins it.
    logic              r_rr_gpu;
`endif

    logic              w_ack_vid;
    logic              w_ack_cpu;
    logic              w_ack_gpu;
    logic              w_elig_vid;
    logic              w_elig_cpu;
    logic              w_elig_gpu;
    logic              w_any_write;
    logic              w_grant;
    logic [1:0]        w_grant_port;

    // Acks come straight from the tag; reset suppresses an in-flight ack so a
    // read interrupted by reset is silently discarded.
    assign w_ack_vid = r_tag_valid && (r_tag_port == c_PORT_VID) && !reset;
    assign w_ack_cpu = r_tag_valid && (r_tag_port == c_PORT_CPU) && !reset;
    assign w_ack_gpu = r_tag_valid && (r_tag_port == c_PORT_GPU) && !reset;

    assign vid_read_ack  = w_ack_vid;
    assign cpu_read_ack  = w_ack_cpu;
    assign gpu_read_ack  = w_ack_gpu;
    assign vid_read_byte = w_ack_vid ? ram_rdata : '0;
    assign cpu_read_byte = w_ack_cpu ? ram_rdata : '0;
    assign gpu_read_byte = w_ack_gpu ? ram_rdata : '0;

    // A port being acked this cycle still has read high (it drops it in the
    // ack cycle); masking it prevents a duplicate grant of the same request.
    assign w_elig_vid  = vid_read && !w_ack_vid;
    assign w_elig_cpu  = cpu_read && !w_ack_cpu;
    assign w_elig_gpu  = gpu_read && !w_ack_gpu;
    assign w_any_write = !reset && (cpu_write || gpu_write);

    // Read grant: only in a write-free cycle, vid always first.
    always_comb begin
        w_grant      = 1'b0;
        w_grant_port = c_PORT_VID;
        if (!reset && !w_any_write) begin
            if (w_elig_vid) begin
                w_grant      = 1'b1;
                w_grant_port = c_PORT_VID;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            end else if (w_elig_cpu && w_elig_gpu) begin
                w_grant      = 1'b1;
                w_grant_port = r_rr_gpu ? c_PORT_GPU : c_PORT_CPU;
`endif
            end else if (w_elig_cpu) begin
                w_grant      = 1'b1;
                w_grant_port = c_PORT_CPU;
            end else if (w_elig_gpu) begin
                w_grant      = 1'b1;
                w_grant_port = c_PORT_GPU;
            end
        end
    end

    // RAM command: write beats read beats idle. CPU write wins a collision.
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = '0;
        ram_addr  = r_last_addr;
        if (reset) begin
            ram_addr = '0;
        end else if (cpu_write) begin
            ram_we    = 1'b1;
            ram_addr  = cpu_write_idx;
            ram_wdata = cpu_write_byte;
        end else if (gpu_write) begin
            ram_we    = 1'b1;
            ram_addr  = gpu_write_idx;
            ram_wdata = gpu_write_byte;
        end else if (w_grant) begin
            case (w_grant_port)
                c_PORT_CPU: ram_addr = cpu_read_idx;
                c_PORT_GPU: ram_addr = gpu_read_idx;
                default:    ram_addr = vid_read_idx;
            endcase
        end
    end

    assign write_conflict = r_conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_valid <= 1'b0;
            r_tag_port  <= c_PORT_VID;
            r_last_addr <= '0;
            r_conflict  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_gpu    <= 1'b0;
`endif
        end else begin
            r_tag_valid <= w_grant;
            if (w_grant) begin
                r_tag_port <= w_grant_port;
            end
            r_last_addr <= ram_addr;
            if (cpu_write && gpu_write) begin
                r_conflict <= 1'b1;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Pointer names the port that did not just get served.
            if (w_grant && (w_grant_port == c_PORT_CPU)) begin
                r_rr_gpu <= 1'b1;
            end else if (w_grant && (w_grant_port == c_PORT_GPU)) begin
                r_rr_gpu <= 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A behavioural RAM sits
//                on the RAM port; a reference model derived from the
//                arbitration rules predicts each read completion and pushes
//                it into a scoreboard queue that a separate monitor pops when
//                the DUT acks. Directed scenarios are followed by random
//                traffic. Honours MEM_ARB_ROUND_ROBIN_EN like the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [2:0]        rd_req;             // index 0 = vid, 1 = cpu, 2 = gpu
    logic [ADDR_W-1:0] rd_idx [3];
    logic              cpu_write, gpu_write;
    logic [ADDR_W-1:0] cpu_widx, gpu_widx;
    logic [DATA_W-1:0] cpu_wdat, gpu_wdat;
    logic              vid_ack, cpu_ack, gpu_ack;
    logic [DATA_W-1:0] vid_byte, cpu_byte, gpu_byte;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              write_conflict;
    logic [2:0]        ack_v;

    assign ack_v = {gpu_ack, cpu_ack, vid_ack};

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_read       (rd_req[1]),
        .cpu_read_idx   (rd_idx[1]),
        .cpu_read_byte  (cpu_byte),
        .cpu_read_ack   (cpu_ack),
        .cpu_write      (cpu_write),
        .cpu_write_idx  (cpu_widx),
        .cpu_write_byte (cpu_wdat),
        .gpu_read       (rd_req[2]),
        .gpu_read_idx   (rd_idx[2]),
        .gpu_read_byte  (gpu_byte),
        .gpu_read_ack   (gpu_ack),
        .gpu_write      (gpu_write),
        .gpu_write_idx  (gpu_widx),
        .gpu_write_byte (gpu_wdat),
        .vid_read       (rd_req[0]),
        .vid_read_idx   (rd_idx[0]),
        .vid_read_byte  (vid_byte),
        .vid_read_ack   (vid_ack),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .write_conflict (write_conflict)
    );

    // Behavioural synchronous RAM and the model's view of its contents.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] byte_of(input int p);
        case (p)
            0:       return vid_byte;
            1:       return cpu_byte;
            default: return gpu_byte;
        endcase
    endfunction

    typedef struct {
        int                due;
        int                port;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sbq[$];

    // ------------------------------------------------------------------
    // Reference model: applies the arbitration rules to the current inputs
    // each cycle and predicts the completion (port, cycle, data).
    // ------------------------------------------------------------------
    int last_grant = -1;
    bit m_conf     = 1'b0;
    bit m_rr_gpu   = 1'b0;

    always @(negedge clk) begin
        int g;
        bit e [3];
        g = -1;
        if (reset) begin
            chk("ram_we_in_reset", 32'(ram_we), 32'd0);
            sbq.delete();
            last_grant = -1;
            m_conf     = 1'b0;
            m_rr_gpu   = 1'b0;
        end else begin
            chk("write_conflict", 32'(write_conflict), 32'(m_conf));
            chk("ram_we", 32'(ram_we), 32'(cpu_write | gpu_write));
            if (cpu_write) begin
                chk("ram_addr_cpu_write", 32'(ram_addr), 32'(cpu_widx));
                chk("ram_wdata_cpu", 32'(ram_wdata), 32'(cpu_wdat));
                ref_mem[cpu_widx] = cpu_wdat;
                if (gpu_write) m_conf = 1'b1;
            end else if (gpu_write) begin
                chk("ram_addr_gpu_write", 32'(ram_addr), 32'(gpu_widx));
                chk("ram_wdata_gpu", 32'(ram_wdata), 32'(gpu_wdat));
                ref_mem[gpu_widx] = gpu_wdat;
            end else begin
                for (int p = 0; p < 3; p++) e[p] = rd_req[p] && (last_grant != p);
                if (e[0])               g = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                else if (e[1] && e[2])  g = m_rr_gpu ? 2 : 1;
`endif
                else if (e[1])          g = 1;
                else if (e[2])          g = 2;
                if (g >= 0) begin
                    chk($sformatf("ram_addr_read_p%0d", g), 32'(ram_addr), 32'(rd_idx[g]));
                    sbq.push_back('{cyc + 1, g, ref_mem[rd_idx[g]]});
                    if (g != 0) m_rr_gpu = (g == 1);
                end
            end
            last_grant = g;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever the DUT acks.
    // ------------------------------------------------------------------
    logic [2:0] prev_ack = 3'b000;

    always @(negedge clk) begin
        if (reset) begin
            chk("ack_in_reset", 32'(ack_v), 32'd0);
            prev_ack = 3'b000;
        end else begin
            if (ack_v != 3'b000) chk("ack_consecutive", 32'(ack_v & prev_ack), 32'd0);
            for (int p = 0; p < 3; p++) begin
                if (ack_v[p]) begin
                    if (sbq.size() == 0 || sbq[0].due != cyc || sbq[0].port != p) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_ack: port %0d acked in cycle %0d, none due", p, cyc);
                    end else begin
                        chk($sformatf("read_byte_p%0d", p), 32'(byte_of(p)), 32'(sbq[0].data));
                        void'(sbq.pop_front());
                    end
                end
            end
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_ack: port %0d no ack in cycle %0d, required ack with %0h",
                         sbq[0].port, sbq[0].due, sbq[0].data);
                void'(sbq.pop_front());
            end
            prev_ack = ack_v;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Advance one cycle. Requesters drop read in their ack cycle unless held;
    // write strobes last one cycle. With allow_new, random traffic is added.
    task automatic tick(input logic [2:0] hold, input bit allow_new);
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
        gpu_write = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (ack_v[p] && !hold[p]) begin
                rd_req[p] = 1'b0;
            end else if (allow_new && !rd_req[p] && $urandom_range(0, 2) == 0) begin
                rd_req[p] = 1'b1;
                rd_idx[p] = ADDR_W'($urandom_range(0, 63));
            end
        end
        if (allow_new) begin
            if ($urandom_range(0, 4) == 0) begin
                cpu_write = 1'b1;
                cpu_widx  = ADDR_W'($urandom_range(0, 63));
                cpu_wdat  = DATA_W'($urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                gpu_write = 1'b1;
                gpu_widx  = ADDR_W'($urandom_range(0, 63));
                gpu_wdat  = DATA_W'($urandom);
            end
        end
    endtask

    // Let outstanding reads finish without issuing new ones.
    task automatic drain();
        int n;
        n = 0;
        while (rd_req != 3'b000 && n < 200) begin
            tick(3'b000, 1'b0);
            n++;
        end
        chk("drain_timeout", 32'(rd_req), 32'd0);
        rd_req = 3'b000;
        tick(3'b000, 1'b0);
        tick(3'b000, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rd_req    = 3'b000;
        cpu_write = 1'b0;
        gpu_write = 1'b0;
        cpu_widx  = '0;
        gpu_widx  = '0;
        cpu_wdat  = '0;
        gpu_wdat  = '0;
        for (int p = 0; p < 3; p++) rd_idx[p] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DATA_W'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[12'h123]     = 8'hA5;
        ref_mem[12'h123] = 8'hA5;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single GPU read of a preloaded location.
        rd_req[2] = 1'b1;
        rd_idx[2] = 12'h123;
        repeat (3) tick(3'b000, 1'b0);

        // CPU read colliding with a GPU write, then read back the write.
        rd_req[1] = 1'b1;
        rd_idx[1] = 12'h200;
        gpu_write = 1'b1;
        gpu_widx  = 12'h1F0;
        gpu_wdat  = 8'h3C;
        repeat (4) tick(3'b000, 1'b0);
        rd_req[1] = 1'b1;
        rd_idx[1] = 12'h1F0;
        repeat (3) tick(3'b000, 1'b0);

        // Three-way contention.
        rd_req    = 3'b111;
        rd_idx[0] = 12'h010;
        rd_idx[1] = 12'h020;
        rd_idx[2] = 12'h030;
        repeat (5) tick(3'b000, 1'b0);

        // GPU holds read through its acks.
        rd_req[2] = 1'b1;
        rd_idx[2] = 12'h321;
        repeat (7) tick(3'b100, 1'b0);
        drain();

        // CPU and GPU both hold requests continuously.
        rd_req[1] = 1'b1;
        rd_idx[1] = 12'h044;
        rd_req[2] = 1'b1;
        rd_idx[2] = 12'h055;
        repeat (8) tick(3'b110, 1'b0);
        drain();

        // Colliding writes to the same address.
        cpu_write = 1'b1;
        cpu_widx  = 12'h100;
        cpu_wdat  = 8'h11;
        gpu_write = 1'b1;
        gpu_widx  = 12'h100;
        gpu_wdat  = 8'h22;
        repeat (3) tick(3'b000, 1'b0);
        chk("conflict_ram_contents", 32'(mem[12'h100]), 32'h11);
        rd_req[1] = 1'b1;
        rd_idx[1] = 12'h100;
        repeat (4) tick(3'b000, 1'b0);
        drain();

        // Reset while a CPU read is in flight.
        rd_req[1] = 1'b1;
        rd_idx[1] = 12'h050;
        tick(3'b000, 1'b0);
        reset  = 1'b1;
        rd_req = 3'b000;
        tick(3'b000, 1'b0);
        @(negedge clk);
        chk("rst_acks", 32'(ack_v), 32'd0);
        chk("rst_bytes", {8'd0, vid_byte, cpu_byte, gpu_byte}, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_write_conflict", 32'(write_conflict), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Random traffic.
        repeat (3000) tick(3'b000, 1'b1);
        drain();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
